// File: rtl/fc_classify_ctrl.sv
// Output-stage controller: captures an FC result vector and scans it one class per cycle.
// It produces the argmax, a one-hot class and the ReLU-normalized values.
// Defining FC_CLASSIFY_HIT_CNT_EN adds saturating hit/total counters with a synchronous clear.
module fc_classify_ctrl #(
    parameter int CLASSIFICATIONS = 10,
    parameter int ELEMENT_SIZE    = 30,
    parameter int NORMALIZED_SIZE = 25,
    parameter int IDX_W           = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic [CLASSIFICATIONS*ELEMENT_SIZE-1:0]    fc_results,
    input  logic [IDX_W-1:0]                           label_index,
    output logic                                       busy,
    output logic                                       done,
    output logic [IDX_W-1:0]                           class_index,
    output logic [CLASSIFICATIONS-1:0]                 class_hotcoded,
    output logic [CLASSIFICATIONS*NORMALIZED_SIZE-1:0] normalized_results,
    output logic                                       correct
`ifdef FC_CLASSIFY_HIT_CNT_EN
    ,
    input  logic                                       clr_counts,
    output logic [15:0]                                hit_count,
    output logic [15:0]                                total_count
`endif
);

    localparam int C     = CLASSIFICATIONS;
    localparam int E     = ELEMENT_SIZE;
    localparam int N     = NORMALIZED_SIZE;
    localparam int SHIFT = E - N;

    // Largest element value that still normalizes to zero.
    localparam logic [E-1:0]       RELU_FLOOR = {{N{1'b0}}, {SHIFT{1'b1}}};
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(C - 1);
    localparam logic [C-1:0]       HOT_ZERO   = {{(C-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;

    state_t           state;
    logic [C*E-1:0]   capture_q;
    logic [C*N-1:0]   staging_q;
    logic [E-1:0]     max_val_q;
    logic [IDX_W-1:0] max_idx_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] label_q;

    logic [E-1:0]     elem;
    logic [N-1:0]     norm;

    // NOTE: every signal written in always_comb is assigned on every path, so no latch is inferred.
    always_comb begin
        elem = capture_q[idx_q*E +: E];
        norm = (elem > RELU_FLOOR) ? elem[E-1:SHIFT] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the capture and staging vectors are reset as well, so a
            // mid-run abort leaves no stale operand or partial result behind.
            state              <= IDLE;
            capture_q          <= '0;
            staging_q          <= '0;
            max_val_q          <= '0;
            max_idx_q          <= '0;
            idx_q              <= '0;
            label_q            <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            class_index        <= '0;
            class_hotcoded     <= '0;
            normalized_results <= '0;
            correct            <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        capture_q <= fc_results;
                        label_q   <= label_index;
                        idx_q     <= '0;
                        busy      <= 1'b1;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    // Strict compare keeps the lowest index on ties; idx 0 always seeds.
                    if (idx_q == '0 || elem > max_val_q) begin
                        max_val_q <= elem;
                        max_idx_q <= idx_q;
                    end
                    staging_q[idx_q*N +: N] <= norm;
                    if (idx_q == LAST_IDX) begin
                        idx_q <= '0;
                        state <= FINISH;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                FINISH: begin
                    normalized_results <= staging_q;
                    class_index        <= max_idx_q;
                    class_hotcoded     <= HOT_ZERO << max_idx_q;
                    correct            <= (max_idx_q == label_q);
                    done               <= 1'b1;
                    busy               <= 1'b0;
                    state              <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FC_CLASSIFY_HIT_CNT_EN
    // Clear has priority over a coinciding FINISH update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count   <= '0;
            total_count <= '0;
        end else if (clr_counts) begin
            hit_count   <= '0;
            total_count <= '0;
        end else if (state == FINISH) begin
            if (total_count != 16'hFFFF)
                total_count <= total_count + 16'd1;
            if (max_idx_q == label_q && hit_count != 16'hFFFF)
                hit_count <= hit_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fc_classify_ctrl.sv
// Self-checking bench for fc_classify_ctrl: vector table, hand-written corner sequences
// and randomized vectors checked against an argmax/normalization reference model.
module tb_fc_classify_ctrl;

    localparam int C  = 10;
    localparam int E  = 30;
    localparam int N  = 25;
    localparam int IW = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [C*E-1:0]     fc_results;
    logic [IW-1:0]      label_index;
    logic               busy;
    logic               done;
    logic [IW-1:0]      class_index;
    logic [C-1:0]       class_hotcoded;
    logic [C*N-1:0]     normalized_results;
    logic               correct;
`ifdef FC_CLASSIFY_HIT_CNT_EN
    logic               clr_counts;
    logic [15:0]        hit_count;
    logic [15:0]        total_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    fc_classify_ctrl #(
        .CLASSIFICATIONS(C), .ELEMENT_SIZE(E), .NORMALIZED_SIZE(N), .IDX_W(IW)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .fc_results(fc_results), .label_index(label_index),
        .busy(busy), .done(done), .class_index(class_index),
        .class_hotcoded(class_hotcoded), .normalized_results(normalized_results),
        .correct(correct)
`ifdef FC_CLASSIFY_HIT_CNT_EN
        , .clr_counts(clr_counts), .hit_count(hit_count), .total_count(total_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string          name;
        logic [C*E-1:0] fc;
        logic [IW-1:0]  label;
        int             exp_idx;
        logic           exp_correct;
        logic [C*N-1:0] exp_norm;
    } vec_t;

    vec_t tbl[4];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [C*E-1:0] pack_e(input int unsigned a[C]);
        logic [C*E-1:0] r;
        for (int i = 0; i < C; i++) r[i*E +: E] = E'(a[i]);
        return r;
    endfunction

    function automatic logic [C*N-1:0] pack_n(input int unsigned a[C]);
        logic [C*N-1:0] r;
        for (int i = 0; i < C; i++) r[i*N +: N] = N'(a[i]);
        return r;
    endfunction

    function automatic logic [C-1:0] hot(input int idx);
        logic [C-1:0] h;
        h = '0;
        h[idx] = 1'b1;
        return h;
    endfunction

    // Reference: first index holding the maximum; normalized value is the element
    // divided by 2^(E-N) when it exceeds 2^(E-N)-1, else zero.
    function automatic void model(input int unsigned e[C], input int lab,
                                  output int idx, output logic corr, output logic [C*N-1:0] nrm);
        int unsigned scale;
        scale = 1 << (E - N);
        idx = 0;
        for (int i = 1; i < C; i++)
            if (e[i] > e[idx]) idx = i;
        corr = (idx == lab);
        nrm = '0;
        for (int i = 0; i < C; i++)
            nrm[i*N +: N] = (e[i] > scale - 1) ? N'(e[i] / scale) : '0;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic launch(input logic [C*E-1:0] fc, input logic [IW-1:0] lab);
        fc_results  = fc;
        label_index = lab;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
    endtask

    task automatic wait_done(output int busy_cycles, output bit seen);
        busy_cycles = 0;
        seen = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic check_result(input string name, input int exp_idx,
                                input logic exp_corr, input logic [C*N-1:0] exp_norm);
        check({name, ".class_index"}, class_index, exp_idx);
        check({name, ".hot"},         class_hotcoded, hot(exp_idx));
        check({name, ".correct"},     correct, exp_corr);
        check({name, ".norm"},        normalized_results, exp_norm);
        check({name, ".busy_in_done"}, busy, 0);
    endtask

    task automatic full_run(input string name, input logic [C*E-1:0] fc, input logic [IW-1:0] lab,
                            input int exp_idx, input logic exp_corr, input logic [C*N-1:0] exp_norm);
        int  bc;
        bit  seen;
        launch(fc, lab);
        wait_done(bc, seen);
        check({name, ".done_seen"}, seen, 1);
        check({name, ".busy_cycles"}, bc, C + 1);
        check_result(name, exp_idx, exp_corr, exp_norm);
        @(negedge clk);
        check({name, ".done_pulse"}, done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int unsigned    tmp[C];
        int unsigned    ntmp[C];
        logic [C*E-1:0] basic_fc, tie_fc;
        logic [C*N-1:0] basic_norm, tie_norm;
        int             bc, cnt, got_idx, m_idx;
        bit             seen;
        logic           m_corr;
        logic [C*N-1:0] m_norm;

        tmp = '{5, 40, 1000, 7, 0, 64, 999, 3, 2, 1};
        basic_fc = pack_e(tmp);
        ntmp = '{0, 1, 31, 0, 0, 2, 31, 0, 0, 0};
        basic_norm = pack_n(ntmp);
        tmp = '{0, 0, 0, 32'h3FFF_FFFF, 0, 0, 0, 32'h3FFF_FFFF, 0, 0};
        tie_fc = pack_e(tmp);
        ntmp = '{0, 0, 0, 32'h1FF_FFFF, 0, 0, 0, 32'h1FF_FFFF, 0, 0};
        tie_norm = pack_n(ntmp);

        tbl[0] = '{name: "basic", fc: basic_fc, label: 2, exp_idx: 2, exp_correct: 1, exp_norm: basic_norm};
        tbl[1] = '{name: "zeros", fc: '0, label: 0, exp_idx: 0, exp_correct: 1, exp_norm: '0};
        tbl[2] = '{name: "tie", fc: tie_fc, label: 7, exp_idx: 3, exp_correct: 0, exp_norm: tie_norm};
        tmp = '{31, 32, 31, 0, 0, 0, 0, 0, 0, 33};
        ntmp = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
        tbl[3] = '{name: "floor", fc: pack_e(tmp), label: 9, exp_idx: 9, exp_correct: 1, exp_norm: pack_n(ntmp)};

        rst = 1'b1;
        start = 1'b0;
        fc_results = '0;
        label_index = '0;
`ifdef FC_CLASSIFY_HIT_CNT_EN
        clr_counts = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.class_index", class_index, 0);
        check("reset.hot", class_hotcoded, 0);
        check("reset.norm", normalized_results, 0);
        check("reset.correct", correct, 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy || done) cnt++;
            @(negedge clk);
        end
        check("idle.no_activity", cnt, 0);

        for (int i = 0; i < 4; i++)
            full_run(tbl[i].name, tbl[i].fc, tbl[i].label, tbl[i].exp_idx,
                     tbl[i].exp_correct, tbl[i].exp_norm);

        // Second start during SCAN must be ignored.
        launch(basic_fc, 2);
        @(negedge clk);
        fc_results = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        got_idx = -1;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                cnt++;
                got_idx = int'(class_index);
            end
            @(negedge clk);
        end
        check("ignore_start.done_count", cnt, 1);
        check("ignore_start.class_index", got_idx, 2);

        // Input changes after capture have no effect.
        launch(tie_fc, 3);
        fc_results = basic_fc;
        label_index = 2;
        wait_done(bc, seen);
        check("alter_fc.done_seen", seen, 1);
        check_result("alter_fc", 3, 1, tie_norm);
        @(negedge clk);

        // Back-to-back: a start in the done cycle is accepted.
        launch(basic_fc, 2);
        wait_done(bc, seen);
        check("b2b_first.done_seen", seen, 1);
        check_result("b2b_first", 2, 1, basic_norm);
        launch(tie_fc, 7);
        wait_done(bc, seen);
        check("b2b_second.done_seen", seen, 1);
        check("b2b_second.busy_cycles", bc, C + 1);
        check_result("b2b_second", 3, 0, tie_norm);
        @(negedge clk);

        // Reset in the 5th SCAN cycle aborts with no done.
        full_run("pre_abort", basic_fc, 2, 2, 1, basic_norm);
        launch(tie_fc, 3);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort.busy", busy, 0);
        check("abort.class_index", class_index, 0);
        check("abort.hot", class_hotcoded, 0);
        check("abort.norm", normalized_results, 0);
        check("abort.correct", correct, 0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) cnt++;
            @(negedge clk);
        end
        check("abort.no_done", cnt, 0);
        full_run("after_abort", basic_fc, 5, 2, 0, basic_norm);

        // Randomized vectors against the reference model.
        for (int r = 0; r < 40; r++) begin
            int lab;
            for (int i = 0; i < C; i++) begin
                case ($urandom_range(0, 2))
                    0: tmp[i] = $urandom() & 32'h3FFF_FFFF;
                    1: tmp[i] = $urandom_range(0, 63);
                    default: begin
                        case ($urandom_range(0, 2))
                            0: tmp[i] = 0;
                            1: tmp[i] = 1000;
                            default: tmp[i] = 32'h3FFF_FFFF;
                        endcase
                    end
                endcase
            end
            lab = $urandom_range(0, C - 1);
            model(tmp, lab, m_idx, m_corr, m_norm);
            full_run($sformatf("rand%0d", r), pack_e(tmp), IW'(lab), m_idx, m_corr, m_norm);
        end

`ifdef FC_CLASSIFY_HIT_CNT_EN
        clr_counts = 1'b1;
        @(negedge clk);
        clr_counts = 1'b0;
        check("cnt.clear_hit", hit_count, 0);
        check("cnt.clear_total", total_count, 0);
        full_run("cnt_run1", basic_fc, 2, 2, 1, basic_norm);
        full_run("cnt_run2", tie_fc, 3, 3, 1, tie_norm);
        full_run("cnt_run3", basic_fc, 4, 2, 0, basic_norm);
        check("cnt.hit", hit_count, 2);
        check("cnt.total", total_count, 3);
        clr_counts = 1'b1;
        full_run("cnt_clr_run", basic_fc, 2, 2, 1, basic_norm);
        clr_counts = 1'b0;
        check("cnt.clr_wins_hit", hit_count, 0);
        check("cnt.clr_wins_total", total_count, 0);
        dut.hit_count = 16'hFFFF;
        dut.total_count = 16'hFFFF;
        full_run("cnt_sat_run", basic_fc, 2, 2, 1, basic_norm);
        check("cnt.sat_hit", hit_count, 16'hFFFF);
        check("cnt.sat_total", total_count, 16'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
